stream_hblur3: RTL and testbench
================================

// Module: stream_hblur3
// PURPOSE
//  Avalon-ST video pre-filter placed directly upstream of the colour-detect/bounding-box stage.
//  Applies a horizontal [1 2 1]/4 smoothing kernel per colour channel to suppress single-pixel noise before thresholding.
//  Control (non-video) packets and the SOP header word pass through bit-exact.
//  Full valid/ready backpressure; one registered output stage.
// PARAMETERS
//  IMAGE_W  640  pixels per row; legal range 2..2047
// PORTS
//  clk          in   1   clock
//  reset_n      in   1   reset, synchronous, active-low
//  sink_data    in   24  {R,G,B} 8b each; on SOP beat data[3:0]==0 marks a video packet
//  sink_valid   in   1   input beat valid
//  sink_ready   out  1   input beat accepted when valid&ready
//  sink_sop     in   1   start of packet
//  sink_eop     in   1   end of packet
//  source_data  out  24  filtered/forwarded pixel
//  source_valid out  1   output beat valid
//  source_ready in   1   downstream ready
//  source_sop   out  1   start of packet
//  source_eop   out  1   end of packet
//  enable       in   1   1=filter video, 0=bypass; sampled only on accepted SOP beat
//  frames_done  out  16  count of video frames completed (wraps)
// BEHAVIOUR
//  - Reset: source_valid=0, source_sop/eop=0, source_data=0, state=HDR, x=0, frames_done=0, enable latch=0.
//  - out_free = ~source_valid | source_ready.
//  - sink_ready = out_free & (state!=FLUSH).
//  - Output register loads only when out_free; if a load is pending and out_free=0, hold all outputs stable.
//  - Filter: per channel s = a + 2b + c (10b); y = (s + 2) >> 2; no overflow possible (max 255).
//  - Left edge replicates pixel 0 (a=b).
//  - Right edge replicates last pixel (c=b).
//  - States:
//   HDR: accepted beat forwarded unmodified, latency 1.
//     If sop: vid = (data[3:0]==0) & enable; x=0.
//     vid -> ROW_FIRST, else PASS.
//     Non-sop beats in HDR are forwarded, state unchanged.
//   PASS: forward unmodified.
//     eop -> HDR; sop -> handled exactly as in HDR.
//   ROW_FIRST: accept p: prev<=p, cur<=p, no output.
//     eop -> FLUSH (held_eop=1); else -> RUN with x=1.
//   RUN: accept p: emit f(prev,cur,p) with sop=0, eop=0; prev<=cur; cur<=p.
//     If eop or x==IMAGE_W-1 -> FLUSH (held_eop=eop); else x<=x+1.
//   FLUSH: accept nothing; when out_free emit f(prev,cur,cur) with eop=held_eop.
//     held_eop -> HDR and frames_done+1; else -> ROW_FIRST with x=0.
//  - Latency: pixel x appears one cycle after pixel x+1 is accepted.
//    Last pixel of a row appears one cycle after FLUSH entry (plus any stall).
//  - Beat count out == beat count in for every packet.
//  - Truncated frame: sop accepted in ROW_FIRST/RUN is treated as a new header.
//    The held pixel is discarded (no eop emitted for the old packet); frames_done is not incremented.
//  - Rows longer than IMAGE_W: the row is split at IMAGE_W; the next pixel starts a new row.
//  - Row count is not checked; frames of any height are accepted.
//  - enable changes mid-packet are ignored until the next SOP.
//  - Reset mid-packet: immediate return to reset values; any output beat in flight is dropped.
// STRUCTURE
//  - Shared package: state enum {HDR,PASS,ROW_FIRST,RUN,FLUSH}, pixel_t (24b), VIDEO_PKT_TYPE=4'h0.
//  - Sub-module hblur3_px: combinational 3-tap kernel on three 24b pixels (three channel instances inside).
//  - Top level holds the FSM, x counter, prev/cur registers and the output register.
// TESTING (IMAGE_W=4 unless noted)
//  1. Reset held 2 cycles, then released -> source_valid=0, sink_ready=1, frames_done=0.
//  2. Video frame, 1 row, R=0,40,80,120, G=B=0, enable=1 -> R out 10,40,80,110.
//     sop on the header only, eop on pixel 3; frames_done=1.
//  3. SOP header data[3:0]=4'hF + 3 beats, last with eop -> all 4 beats forwarded bit-exact; frames_done unchanged.
//  4. 2-row frame with random 50% source_ready and random sink_valid gaps -> output identical to the no-stall run.
//     sink_ready=0 in every FLUSH cycle; no beat lost or duplicated.
//  5. enable=0 at SOP, then toggled to 1 mid-frame -> whole frame passes unmodified.
//  6. Pixels 10,20 then eop on pixel 2 (value 30) -> outputs 13,20,28 with eop on the third beat.
//     Next SOP is accepted in HDR.
//     Also: reset asserted mid-row -> reset values, and the following frame filters correctly.

Source files
------------

// File: rtl/stream_hblur3_pkg.sv
// Shared types and constants for the stream_hblur3 horizontal blur pre-filter.
//   state_e : top-level packet/row FSM states
//   pixel_t : packed {R,G,B} pixel, 8 bits per channel
package stream_hblur3_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [2:0] {
    StHdr,
    StPass,
    StRowFirst,
    StRun,
    StFlush
  } state_e;

  // Low nibble of the SOP word that identifies a video packet.
  localparam logic [3:0] VIDEO_PKT_TYPE = 4'h0;

  // Column counter width; enough for rows up to 2047 pixels.
  localparam int unsigned XW = 11;

endpackage

// File: rtl/hblur3_px.sv
// Combinational 3-tap [1 2 1]/4 horizontal kernel on three 24-bit pixels.
//   a_i : left neighbour
//   b_i : centre pixel
//   c_i : right neighbour
//   y_o : filtered pixel, each channel rounded: (a + 2b + c + 2) >> 2
module hblur3_px
  import stream_hblur3_pkg::*;
(
  input  pixel_t a_i,
  input  pixel_t b_i,
  input  pixel_t c_i,
  output pixel_t y_o
);

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    logic [9:0] sum;

    // Max 255*4 + 2 = 1022, so 10 bits never overflow.
    assign sum = {2'b00, a_i[ch*8 +: 8]} + {1'b0, b_i[ch*8 +: 8], 1'b0} +
                 {2'b00, c_i[ch*8 +: 8]} + 10'd2;
    assign y_o[ch*8 +: 8] = 8'(sum >> 2);
  end

endmodule

// File: rtl/stream_hblur3.sv
// Avalon-ST video pre-filter: horizontal [1 2 1]/4 blur per colour channel on video packets,
// bit-exact pass-through for control packets and SOP header words. One registered output stage.
//   clk, reset_n        : clock, synchronous active-low reset
//   sink_*              : upstream Avalon-ST sink (data/valid/ready/sop/eop)
//   source_*            : downstream Avalon-ST source (data/valid/ready/sop/eop)
//   enable              : 1 = filter video, 0 = bypass; sampled on the accepted SOP beat only
//   frames_done         : wrapping count of completed video frames
module stream_hblur3
  import stream_hblur3_pkg::*;
#(
  parameter int unsigned IMAGE_W = 640
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] sink_data,
  input  logic        sink_valid,
  output logic        sink_ready,
  input  logic        sink_sop,
  input  logic        sink_eop,
  output logic [23:0] source_data,
  output logic        source_valid,
  input  logic        source_ready,
  output logic        source_sop,
  output logic        source_eop,
  input  logic        enable,
  output logic [15:0] frames_done
);

  localparam logic [XW-1:0] XLast = XW'(IMAGE_W - 1);

  state_e        state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  pixel_t        prev_q, prev_d;
  pixel_t        cur_q, cur_d;
  logic          held_eop_q, held_eop_d;
  logic          out_valid_q, out_valid_d;
  logic          out_sop_q, out_sop_d;
  logic          out_eop_q, out_eop_d;
  pixel_t        out_data_q, out_data_d;
  logic [15:0]   frames_q, frames_d;

  logic   out_free;
  logic   accept;
  pixel_t tap_c;
  pixel_t blur_y;

  assign out_free   = ~out_valid_q | source_ready;
  assign sink_ready = out_free & (state_q != StFlush);
  assign accept     = sink_valid & sink_ready;

  // In FLUSH the right neighbour is replicated from the last pixel of the row.
  assign tap_c = (state_q == StFlush) ? cur_q : sink_data;

  hblur3_px u_px (
    .a_i (prev_q),
    .b_i (cur_q),
    .c_i (tap_c),
    .y_o (blur_y)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    prev_d      = prev_q;
    cur_d       = cur_q;
    held_eop_d  = held_eop_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_data_d  = out_data_q;
    frames_d    = frames_q;

    // Current beat drains this cycle; a new load below may replace it.
    if (out_free) begin
      out_valid_d = 1'b0;
    end

    if (accept && sink_sop) begin
      // Any SOP (including one that truncates a video row) starts a new packet;
      // a pixel held for the old row is simply abandoned.
      out_valid_d = 1'b1;
      out_sop_d   = 1'b1;
      out_eop_d   = sink_eop;
      out_data_d  = sink_data;
      x_d         = '0;
      if ((sink_data[3:0] == VIDEO_PKT_TYPE) && enable) begin
        state_d = StRowFirst;
      end else begin
        state_d = StPass;
      end
    end else begin
      case (state_q)
        StHdr, StPass: begin
          if (accept) begin
            out_valid_d = 1'b1;
            out_sop_d   = sink_sop;
            out_eop_d   = sink_eop;
            out_data_d  = sink_data;
            if ((state_q == StPass) && sink_eop) begin
              state_d = StHdr;
            end
          end
        end
        StRowFirst: begin
          if (accept) begin
            // Left edge: pixel 0 doubles as its own left neighbour.
            prev_d = sink_data;
            cur_d  = sink_data;
            if (sink_eop) begin
              held_eop_d = 1'b1;
              state_d    = StFlush;
            end else begin
              x_d     = XW'(1);
              state_d = StRun;
            end
          end
        end
        StRun: begin
          if (accept) begin
            out_valid_d = 1'b1;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b0;
            out_data_d  = blur_y;
            prev_d      = cur_q;
            cur_d       = sink_data;
            if (sink_eop || (x_q == XLast)) begin
              held_eop_d = sink_eop;
              state_d    = StFlush;
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end
        StFlush: begin
          if (out_free) begin
            out_valid_d = 1'b1;
            out_sop_d   = 1'b0;
            out_eop_d   = held_eop_q;
            out_data_d  = blur_y;
            if (held_eop_q) begin
              frames_d = frames_q + 16'd1;
              state_d  = StHdr;
            end else begin
              x_d     = '0;
              state_d = StRowFirst;
            end
          end
        end
        default: begin
          state_d = StHdr;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StHdr;
      x_q         <= '0;
      prev_q      <= '0;
      cur_q       <= '0;
      held_eop_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_data_q  <= '0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      prev_q      <= prev_d;
      cur_q       <= cur_d;
      held_eop_q  <= held_eop_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_data_q  <= out_data_d;
      frames_q    <= frames_d;
    end
  end

  assign source_valid = out_valid_q;
  assign source_sop   = out_sop_q;
  assign source_eop   = out_eop_q;
  assign source_data  = out_data_q;
  assign frames_done  = frames_q;

endmodule

// File: tb/tb_stream_hblur3.sv
// Self-checking bench for stream_hblur3 (IMAGE_W = 4): directed vector table, hand-written
// reset sequences, and randomized packets with stalls checked against a packet-level model.
module tb_stream_hblur3;

  localparam int unsigned ImageW = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [23:0] sink_data = '0;
  logic        sink_valid = 1'b0;
  logic        sink_ready;
  logic        sink_sop = 1'b0;
  logic        sink_eop = 1'b0;
  logic [23:0] source_data;
  logic        source_valid;
  logic        source_ready = 1'b1;
  logic        source_sop;
  logic        source_eop;
  logic        enable = 1'b0;
  logic [15:0] frames_done;

  int checks = 0;
  int failures = 0;
  bit stall_mode = 1'b0;

  logic [25:0] out_q[$];   // {sop, eop, data} as observed on the source side
  logic [25:0] exp_q[$];   // model expectation
  logic [23:0] pkt_q[$];   // beats of the packet being built
  int          exp_frames = 0;

  typedef struct {
    logic [23:0] d;
    logic        sop;
    logic        eop;
    logic        en;
    logic [23:0] xd;
    logic        xsop;
    logic        xeop;
  } vec_t;
  vec_t tbl[$];

  stream_hblur3 #(.IMAGE_W(ImageW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sink_data    (sink_data),
    .sink_valid   (sink_valid),
    .sink_ready   (sink_ready),
    .sink_sop     (sink_sop),
    .sink_eop     (sink_eop),
    .source_data  (source_data),
    .source_valid (source_valid),
    .source_ready (source_ready),
    .source_sop   (source_sop),
    .source_eop   (source_eop),
    .enable       (enable),
    .frames_done  (frames_done)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endfunction

  // Downstream backpressure.
  always @(posedge clk) begin
    #1;
    source_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output monitor; also requires a stalled beat to stay put until taken.
  bit          was_stalled = 1'b0;
  logic [25:0] held_beat = '0;
  always @(negedge clk) begin
    if (!reset_n) begin
      was_stalled = 1'b0;
    end else begin
      if (was_stalled) begin
        check("stall_hold", {5'd0, source_valid, source_sop, source_eop, source_data},
              {5'd0, 1'b1, held_beat});
      end
      if (source_valid && source_ready) begin
        out_q.push_back({source_sop, source_eop, source_data});
      end
      was_stalled = source_valid && !source_ready;
      held_beat   = {source_sop, source_eop, source_data};
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [23:0] blur(logic [23:0] a, logic [23:0] b, logic [23:0] c);
    logic [23:0] y;
    for (int ch = 0; ch < 3; ch++) begin
      int s;
      s = int'(a[ch*8 +: 8]) + 2 * int'(b[ch*8 +: 8]) + int'(c[ch*8 +: 8]);
      y[ch*8 +: 8] = 8'((s + 2) / 4);
    end
    return y;
  endfunction

  task automatic emit_row(input logic [23:0] row[$], input bit last);
    int n;
    n = row.size();
    for (int j = 0; j < n; j++) begin
      logic [23:0] a, c;
      a = row[(j == 0) ? 0 : j - 1];
      c = row[(j == n - 1) ? n - 1 : j + 1];
      exp_q.push_back({1'b0, last && (j == n - 1), blur(a, row[j], c)});
    end
  endtask

  task automatic model_packet(input bit en);
    logic [23:0] row[$];
    int          n;
    bit          vid;
    n   = pkt_q.size();
    vid = (pkt_q[0][3:0] == 4'h0) && en;
    exp_q.push_back({1'b1, n == 1, pkt_q[0]});
    if (!vid) begin
      for (int i = 1; i < n; i++) exp_q.push_back({1'b0, i == n - 1, pkt_q[i]});
    end else begin
      for (int i = 1; i < n; i++) begin
        row.push_back(pkt_q[i]);
        if (row.size() == ImageW || i == n - 1) begin
          emit_row(row, i == n - 1);
          row.delete();
        end
      end
      exp_frames++;
    end
  endtask

  // ---------------- drivers ----------------
  // Entered and left just after a rising edge.
  task automatic send_beat(input logic [23:0] d, input bit sop, input bit eop, input bit en,
                           input bit gaps);
    int t;
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    sink_data  = d;
    sink_sop   = sop;
    sink_eop   = eop;
    enable     = en;
    sink_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!sink_ready && t < 1000) begin
      t++;
      @(negedge clk);
    end
    if (!sink_ready) begin
      failures++;
      $display("FAIL sink_ready_timeout: got 0 expected 1");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "sink stuck");
    end
    @(posedge clk);
    #1;
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  task automatic send_packet(input bit video, input int npix, input bit en, input bit gaps);
    logic [23:0] h;
    h = 24'($urandom);
    h[3:0] = video ? 4'h0 : 4'($urandom_range(1, 15));
    pkt_q.delete();
    pkt_q.push_back(h);
    for (int i = 0; i < npix; i++) pkt_q.push_back(24'($urandom));
    model_packet(en);
    for (int i = 0; i < pkt_q.size(); i++) begin
      // Enable is randomised after the header; the DUT must ignore it until the next SOP.
      send_beat(pkt_q[i], i == 0, i == pkt_q.size() - 1, (i == 0) ? en : 1'($urandom), gaps);
    end
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (out_q.size() < n && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (5) @(posedge clk);
    #1;
    check("beat_count", 32'(out_q.size()), 32'(n));
  endtask

  task automatic compare_model(input string name);
    wait_out(exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      check(name, {6'd0, out_q[i]}, {6'd0, exp_q[i]});
    end
    out_q.delete();
    exp_q.delete();
  endtask

  task automatic add(input logic [23:0] d, input bit sop, input bit eop, input bit en,
                     input logic [23:0] xd, input bit xsop, input bit xeop);
    vec_t v;
    v.d = d; v.sop = sop; v.eop = eop; v.en = en;
    v.xd = xd; v.xsop = xsop; v.xeop = xeop;
    tbl.push_back(v);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    // Single-row video frame, R ramp.
    add(24'h000000, 1, 0, 1, 24'h000000, 1, 0);
    add(24'h000000, 0, 0, 1, 24'h0A0000, 0, 0);
    add(24'h280000, 0, 0, 1, 24'h280000, 0, 0);
    add(24'h500000, 0, 0, 1, 24'h500000, 0, 0);
    add(24'h780000, 0, 1, 1, 24'h6E0000, 0, 1);
    // Short row ending in eop: 10,20,30 -> 13,20,28.
    add(24'h000000, 1, 0, 1, 24'h000000, 1, 0);
    add(24'h0A0A0A, 0, 0, 1, 24'h0D0D0D, 0, 0);
    add(24'h141414, 0, 0, 1, 24'h141414, 0, 0);
    add(24'h1E1E1E, 0, 1, 1, 24'h1C1C1C, 0, 1);
    // Control packet, type 0xF: bit-exact.
    add(24'h00000F, 1, 0, 1, 24'h00000F, 1, 0);
    add(24'h123456, 0, 0, 1, 24'h123456, 0, 0);
    add(24'hABCDEF, 0, 0, 1, 24'hABCDEF, 0, 0);
    add(24'h7890AB, 0, 1, 1, 24'h7890AB, 0, 1);
    // Video packet with enable=0 at SOP, enable=1 afterwards: bit-exact.
    add(24'h123450, 1, 0, 0, 24'h123450, 1, 0);
    add(24'h102030, 0, 0, 1, 24'h102030, 0, 0);
    add(24'h405060, 0, 0, 1, 24'h405060, 0, 0);
    add(24'h708090, 0, 1, 1, 24'h708090, 0, 1);
    // Five pixels: row split at 4, then a one-pixel row; blue channel only.
    add(24'h000000, 1, 0, 1, 24'h000000, 1, 0);
    add(24'h000004, 0, 0, 1, 24'h000005, 0, 0);
    add(24'h000008, 0, 0, 1, 24'h000008, 0, 0);
    add(24'h00000C, 0, 0, 1, 24'h00000C, 0, 0);
    add(24'h000010, 0, 0, 1, 24'h00000F, 0, 0);
    add(24'h000014, 0, 1, 1, 24'h000014, 0, 1);

    // Reset held two cycles.
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    #1;
    check("rst_source_valid", 32'(source_valid), 32'd0);
    check("rst_source_sop", 32'(source_sop), 32'd0);
    check("rst_source_eop", 32'(source_eop), 32'd0);
    check("rst_source_data", 32'(source_data), 32'd0);
    check("rst_sink_ready", 32'(sink_ready), 32'd1);
    check("rst_frames_done", 32'(frames_done), 32'd0);

    // Directed vector table.
    @(posedge clk);
    #1;
    foreach (tbl[i]) send_beat(tbl[i].d, tbl[i].sop, tbl[i].eop, tbl[i].en, 1'b0);
    wait_out(tbl.size());
    foreach (tbl[i]) begin
      if (i < out_q.size()) begin
        check($sformatf("vec%0d", i), {6'd0, out_q[i]}, {6'd0, tbl[i].xsop, tbl[i].xeop, tbl[i].xd});
      end
    end
    check("vec_frames_done", 32'(frames_done), 32'd3);
    out_q.delete();

    // Randomised traffic with stalls on both sides; starts with a two-row frame.
    exp_frames = 3;
    stall_mode = 1'b1;
    send_packet(1'b1, 2 * ImageW, 1'b1, 1'b1);
    for (int p = 0; p < 25; p++) begin
      send_packet(1'($urandom), $urandom_range(1, 10), 1'($urandom), 1'($urandom));
    end
    stall_mode = 1'b0;
    compare_model("rand_beat");
    check("rand_frames_done", 32'(frames_done), 32'(exp_frames[15:0]));

    // Reset in the middle of a video row.
    send_beat(24'h000000, 1'b1, 1'b0, 1'b1, 1'b0);
    send_beat(24'h112233, 1'b0, 1'b0, 1'b1, 1'b0);
    send_beat(24'h445566, 1'b0, 1'b0, 1'b1, 1'b0);
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_source_valid", 32'(source_valid), 32'd0);
    check("midrst_source_data", 32'(source_data), 32'd0);
    check("midrst_frames_done", 32'(frames_done), 32'd0);
    check("midrst_sink_ready", 32'(sink_ready), 32'd1);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    out_q.delete();
    exp_q.delete();
    exp_frames = 0;
    send_packet(1'b1, 6, 1'b1, 1'b0);
    compare_model("postrst_beat");
    check("postrst_frames_done", 32'(frames_done), 32'(exp_frames[15:0]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
